// File: rtl/imm_ext_ctrl.sv
// ---------------------------------------------------------------------------
// imm_ext_ctrl
//   Decode-stage immediate unit. Each accepted instruction word is decoded
//   into an extension mode (SIGN / ZERO / LUI / BRANCH) from its opcode, the
//   raw immediate is extended to DATA_W bits, and the {mode, imm} pair is
//   queued in a 2-entry FIFO that the EX operand mux drains. A saturating
//   counter tracks cycles in which a result is waiting but not accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_instr valid this cycle
//   in_ready   FIFO has room (registered count only)
//   in_instr   instruction word, opcode [31:26], immediate [15:0]
//   flush      synchronous discard of every buffered entry
//   out_valid  head entry valid
//   out_ready  consumer accepts head entry
//   out_imm    extended immediate of head entry
//   out_mode   00 SIGN, 01 ZERO, 10 LUI, 11 BRANCH
//   stall_clr  synchronous clear of stall_cnt
//   stall_cnt  saturating count of out_valid & !out_ready cycles
// ---------------------------------------------------------------------------
module imm_ext_ctrl #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic [1:0]        out_mode,
   input  logic              stall_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] MODE_SIGN   = 2'b00;
   localparam logic [1:0] MODE_ZERO   = 2'b01;
   localparam logic [1:0] MODE_LUI    = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   function automatic logic [1:0] decode_mode(input logic [5:0] op);
      case (op)
         6'h0C, 6'h0D, 6'h0E: decode_mode = MODE_ZERO;
         6'h0F:               decode_mode = MODE_LUI;
         6'h04, 6'h05:        decode_mode = MODE_BRANCH;
         default:             decode_mode = MODE_SIGN;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [1:0] mode,
                                                input logic [IMM_W-1:0] imm);
      logic s;
      s = imm[IMM_W-1];
      case (mode)
         MODE_ZERO:   extend = {{(DATA_W-IMM_W){1'b0}}, imm};
         MODE_LUI:    extend = {imm, {(DATA_W-IMM_W){1'b0}}};
         MODE_BRANCH: extend = {{(DATA_W-IMM_W-2){s}}, imm, 2'b00};
         default:     extend = {{(DATA_W-IMM_W){s}}, imm};
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [DATA_W-1:0] mem_imm [2];
   logic [1:0]        mem_mode [2];
   logic [1:0]        count;
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;
   logic [1:0]        new_mode;
   logic [DATA_W-1:0] new_imm;

   // Instruction bits between opcode and immediate carry no information here.
   logic unused_bits;
   assign unused_bits = ^in_instr[DATA_W-7:IMM_W];

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_imm   = mem_imm[rd_ptr];
   assign out_mode  = mem_mode[rd_ptr];

   // flush outranks both sides of the handshake
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   assign new_mode = decode_mode(in_instr[DATA_W-1:DATA_W-6]);
   assign new_imm  = extend(new_mode, in_instr[IMM_W-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mem_imm[i]  <= '0;
            mem_mode[i] <= MODE_SIGN;
         end
      end else if (flush) begin
         // Align write pointer to read pointer so the head slot (and hence
         // out_imm/out_mode) keeps its last value while empty.
         count  <= 2'd0;
         wr_ptr <= rd_ptr;
      end else begin
         if (push) begin
            mem_imm[wr_ptr]  <= new_imm;
            mem_mode[wr_ptr] <= new_mode;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule
